mem_arbiter: RTL and testbench

Two-requester memory arbiter that lets the instruction fetch unit and the load/store unit share one memory port. It sits between `ifu`/LSU and the single external memory interface. It arbitrates with LSU priority plus an anti-starvation streak limit, and keeps one transaction in flight at a time. Read data and write acknowledges are routed back to the owning requester.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/arb_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the two-requester memory arbiter.
package defines;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_WAIT_GNT = 2'd1,
        ARB_WAIT_RSP = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_IFU = 1'b0,
        ARB_OWN_LSU = 1'b1
    } arb_owner_e;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: LSU first unless its streak has hit the limit
// while IFU is also waiting.
module arb_pick
    import defines::*;
(
    input  logic       ifu_req,
    input  logic       lsu_req,
    input  logic       streak_full,
    output logic       valid,
    output arb_owner_e owner
);

    always_comb begin
        valid = ifu_req | lsu_req;
        owner = ARB_OWN_IFU;
        if (lsu_req && !(ifu_req && streak_full)) begin
            owner = ARB_OWN_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight,
// LSU priority bounded by a streak limit so fetch cannot starve.
module mem_arbiter
    import defines::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int MAX_LSU_STREAK = 4,
    localparam int STREAK_W      = $clog2(MAX_LSU_STREAK + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                ifu_req_i,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_gnt_o,
    output logic                ifu_rvalid_o,
    output logic [DATA_W-1:0]   ifu_rdata_o,

    input  logic                lsu_req_i,
    input  logic                lsu_wen_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wmask_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,

    output logic                mem_req_o,
    output logic                mem_wen_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,

    output logic [1:0]          state_dbg,
    output logic [STREAK_W-1:0] streak_dbg
);

    // Handshake: a requester holds req and payload until its gnt pulse; the
    // memory side sees mem_req_o held until mem_gnt_i, then exactly one
    // mem_rvalid_i per accepted request. Responses outside WAIT_RSP are dropped.

    arb_state_e          state;
    arb_state_e          state_nxt;
    arb_owner_e          owner;
    logic [STREAK_W-1:0] streak;

    logic                pay_wen;
    logic [ADDR_W-1:0]   pay_addr;
    logic [DATA_W-1:0]   pay_wdata;
    logic [DATA_W/8-1:0] pay_wmask;

    logic                pick_valid;
    arb_owner_e          pick_owner;
    logic                streak_full;
    logic                take;

    assign streak_full = (streak == STREAK_W'(MAX_LSU_STREAK));
    assign take        = (state == ARB_IDLE) && pick_valid;

    arb_pick u_pick (
        .ifu_req     (ifu_req_i),
        .lsu_req     (lsu_req_i),
        .streak_full (streak_full),
        .valid       (pick_valid),
        .owner       (pick_owner)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:     if (pick_valid)   state_nxt = ARB_WAIT_GNT;
            ARB_WAIT_GNT: if (mem_gnt_i)    state_nxt = ARB_WAIT_RSP;
            ARB_WAIT_RSP: if (mem_rvalid_i) state_nxt = ARB_IDLE;
            default:                        state_nxt = ARB_IDLE;
        endcase
    end

    // Grants and responses are routed combinationally so the data path adds no latency.
    always_comb begin
        mem_req_o    = 1'b0;
        ifu_gnt_o    = 1'b0;
        lsu_gnt_o    = 1'b0;
        ifu_rvalid_o = 1'b0;
        lsu_rvalid_o = 1'b0;
        ifu_rdata_o  = '0;
        lsu_rdata_o  = '0;
        case (state)
            ARB_WAIT_GNT: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    ifu_gnt_o = (owner == ARB_OWN_IFU);
                    lsu_gnt_o = (owner == ARB_OWN_LSU);
                end
            end
            ARB_WAIT_RSP: begin
                if (mem_rvalid_i) begin
                    if (owner == ARB_OWN_IFU) begin
                        ifu_rvalid_o = 1'b1;
                        ifu_rdata_o  = mem_rdata_i;
                    end else begin
                        lsu_rvalid_o = 1'b1;
                        lsu_rdata_o  = mem_rdata_i;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner     <= ARB_OWN_IFU;
            streak    <= '0;
            pay_wen   <= 1'b0;
            pay_addr  <= '0;
            pay_wdata <= '0;
            pay_wmask <= '0;
        end else if (take) begin
            owner <= pick_owner;
            if (pick_owner == ARB_OWN_LSU) begin
                pay_wen   <= lsu_wen_i;
                pay_addr  <= lsu_addr_i;
                pay_wdata <= lsu_wdata_i;
                pay_wmask <= lsu_wmask_i;
                // Only LSU wins that actually held off a waiting fetch count.
                if (!ifu_req_i) begin
                    streak <= '0;
                end else if (!streak_full) begin
                    streak <= streak + STREAK_W'(1);
                end
            end else begin
                pay_wen   <= 1'b0;
                pay_addr  <= ifu_addr_i;
                pay_wdata <= '0;
                pay_wmask <= '0;
                streak    <= '0;
            end
        end
    end

    assign mem_wen_o   = pay_wen;
    assign mem_addr_o  = pay_addr;
    assign mem_wdata_o = pay_wdata;
    assign mem_wmask_o = pay_wmask;
    assign state_dbg   = state;
    assign streak_dbg  = streak;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, stores, priority, starvation limit,
// back-pressure with a stray response, and reset during a response wait.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req;
    logic [63:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [63:0] ifu_rdata;
    logic        lsu_req;
    logic        lsu_wen;
    logic [63:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [63:0] lsu_rdata;
    logic        mem_req;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic [1:0]  state_dbg;
    logic [2:0]  streak_dbg;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_LSU_STREAK(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ifu_req_i    (ifu_req),
        .ifu_addr_i   (ifu_addr),
        .ifu_gnt_o    (ifu_gnt),
        .ifu_rvalid_o (ifu_rvalid),
        .ifu_rdata_o  (ifu_rdata),
        .lsu_req_i    (lsu_req),
        .lsu_wen_i    (lsu_wen),
        .lsu_addr_i   (lsu_addr),
        .lsu_wdata_i  (lsu_wdata),
        .lsu_wmask_i  (lsu_wmask),
        .lsu_gnt_o    (lsu_gnt),
        .lsu_rvalid_o (lsu_rvalid),
        .lsu_rdata_o  (lsu_rdata),
        .mem_req_o    (mem_req),
        .mem_wen_o    (mem_wen),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_wmask_o  (mem_wmask),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .state_dbg    (state_dbg),
        .streak_dbg   (streak_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_mem_req"},    64'(mem_req),    64'd0);
        check({tag, "_ifu_gnt"},    64'(ifu_gnt),    64'd0);
        check({tag, "_lsu_gnt"},    64'(lsu_gnt),    64'd0);
        check({tag, "_ifu_rvalid"}, 64'(ifu_rvalid), 64'd0);
        check({tag, "_lsu_rvalid"}, 64'(lsu_rvalid), 64'd0);
    endtask

    // Called at a negedge where requests have just been driven with the DUT in IDLE.
    // drop: 0 keep requests, 1 drop the winner's request at grant, 2 drop both.
    task automatic run_txn(input string tag, input bit exp_lsu,
                           input logic [63:0] exp_addr, input bit exp_wen,
                           input logic [63:0] exp_wdata, input logic [7:0] exp_wmask,
                           input int gnt_wait, input int stray_at, input int rsp_wait,
                           input logic [63:0] rdata, input int drop, input int exp_streak);
        for (int i = 0; i <= gnt_wait; i++) begin
            @(negedge clk);
            mem_rvalid = (i == stray_at);
            mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            mem_gnt    = (i == gnt_wait);
            #1;
            check({tag, "_state_wg"}, 64'(state_dbg), 64'd1);
            check({tag, "_mem_req"},  64'(mem_req),   64'd1);
            check({tag, "_addr"},     mem_addr,       exp_addr);
            check({tag, "_wen"},      64'(mem_wen),   64'(exp_wen));
            check({tag, "_wdata"},    mem_wdata,      exp_wdata);
            check({tag, "_wmask"},    64'(mem_wmask), 64'(exp_wmask));
            check({tag, "_ifu_rv_wg"}, 64'(ifu_rvalid), 64'd0);
            check({tag, "_lsu_rv_wg"}, 64'(lsu_rvalid), 64'd0);
            check({tag, "_ifu_gnt"}, 64'(ifu_gnt), 64'((i == gnt_wait) && !exp_lsu));
            check({tag, "_lsu_gnt"}, 64'(lsu_gnt), 64'((i == gnt_wait) && exp_lsu));
            if (i == gnt_wait) begin
                check({tag, "_streak"}, 64'(streak_dbg), 64'(exp_streak));
                if (drop == 2) begin
                    ifu_req = 1'b0;
                    lsu_req = 1'b0;
                end else if (drop == 1) begin
                    if (exp_lsu) lsu_req = 1'b0;
                    else         ifu_req = 1'b0;
                end
            end
        end
        for (int i = 0; i <= rsp_wait; i++) begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = (i == rsp_wait);
            mem_rdata  = rdata;
            #1;
            check({tag, "_state_wr"}, 64'(state_dbg), 64'd2);
            check({tag, "_mem_req_wr"}, 64'(mem_req), 64'd0);
            check({tag, "_ifu_rvalid"}, 64'(ifu_rvalid), 64'((i == rsp_wait) && !exp_lsu));
            check({tag, "_lsu_rvalid"}, 64'(lsu_rvalid), 64'((i == rsp_wait) && exp_lsu));
            if (i == rsp_wait && !exp_wen) begin
                if (exp_lsu) check({tag, "_lsu_rdata"}, lsu_rdata, rdata);
                else         check({tag, "_ifu_rdata"}, ifu_rdata, rdata);
            end
            if (i == rsp_wait) begin
                if (exp_lsu) check({tag, "_ifu_rdata0"}, ifu_rdata, 64'd0);
                else         check({tag, "_lsu_rdata0"}, lsu_rdata, 64'd0);
            end
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check({tag, "_state_idle"}, 64'(state_dbg), 64'd0);
        check_quiet_outputs({tag, "_idle"});
    endtask

    localparam bit [9:0] STARVE_LSU = 10'b1111011110;
    int starve_streak[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

    initial begin
        rst = 1'b1;
        ifu_req = 1'b0; ifu_addr = '0;
        lsu_req = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_state",  64'(state_dbg),  64'd0);
        check("rst_streak", 64'(streak_dbg), 64'd0);
        check("rst_addr",   mem_addr,        64'd0);
        check("rst_wen",    64'(mem_wen),    64'd0);
        check("rst_wdata",  mem_wdata,       64'd0);
        check("rst_wmask",  64'(mem_wmask),  64'd0);
        check("rst_ifu_rdata", ifu_rdata,    64'd0);
        check("rst_lsu_rdata", lsu_rdata,    64'd0);
        check_quiet_outputs("rst");

        // IFU-only read, response two cycles after the grant
        @(negedge clk);
        ifu_req = 1'b1; ifu_addr = 64'h8000_0000;
        run_txn("ifu_rd", 1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'h00,
                0, -1, 1, 64'h0010_0093, 1, 0);

        // LSU store, immediate grant and ack
        lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_1000;
        lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
        run_txn("lsu_st", 1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F,
                0, -1, 0, 64'd0, 1, 0);

        // Simultaneous: LSU load first, then the waiting fetch
        ifu_req = 1'b1; ifu_addr = 64'h8000_0040;
        lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_2000;
        lsu_wdata = 64'd0; lsu_wmask = 8'hFF;
        run_txn("sim_l", 1'b1, 64'h8000_2000, 1'b0, 64'd0, 8'hFF,
                0, -1, 0, 64'h1111_2222_3333_4444, 1, 1);
        run_txn("sim_i", 1'b0, 64'h8000_0040, 1'b0, 64'd0, 8'h00,
                0, -1, 0, 64'h0000_0013, 1, 0);

        // Starvation: both held high, fetch wins every fifth slot
        ifu_req = 1'b1; ifu_addr = 64'h8000_0080;
        lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_3000;
        lsu_wdata = 64'd0; lsu_wmask = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            if (STARVE_LSU[9-i])
                run_txn($sformatf("starve%0d", i), 1'b1, 64'h8000_3000, 1'b0, 64'd0, 8'hFF,
                        0, -1, 0, 64'h1000 + 64'(i), (i == 9) ? 2 : 0, starve_streak[i]);
            else
                run_txn($sformatf("starve%0d", i), 1'b0, 64'h8000_0080, 1'b0, 64'd0, 8'h00,
                        0, -1, 0, 64'h1000 + 64'(i), (i == 9) ? 2 : 0, starve_streak[i]);
        end

        // Back-pressure for 5 cycles, stray response on the last held cycle
        lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_4000;
        lsu_wdata = 64'h0123_4567_89AB_CDEF; lsu_wmask = 8'hF0;
        run_txn("bp", 1'b1, 64'h8000_4000, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0,
                5, 4, 0, 64'd0, 1, 0);

        // Reset while waiting for a response; the late response must be dropped
        ifu_req = 1'b1; ifu_addr = 64'h8000_00C0;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        check("rstw_ifu_gnt", 64'(ifu_gnt), 64'd1);
        ifu_req = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        check("rstw_state_wr", 64'(state_dbg), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hFEED_FACE;
        #1;
        check("rstw_state", 64'(state_dbg), 64'd0);
        check("rstw_addr",  mem_addr,       64'd0);
        check("rstw_wen",   64'(mem_wen),   64'd0);
        check("rstw_ifu_rdata", ifu_rdata,  64'd0);
        check_quiet_outputs("rstw");
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("rstw_still_idle", 64'(state_dbg), 64'd0);
        ifu_req = 1'b1; ifu_addr = 64'h8000_0100;
        run_txn("post_rst", 1'b0, 64'h8000_0100, 1'b0, 64'd0, 8'h00,
                0, -1, 0, 64'h0000_0513, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
